// File: rtl/dot_accum_pkg.sv
// Shared widths, tree sizing and beat-mode encoding for the dot-product accumulate engine.
package dot_accum_pkg;

  typedef enum logic {
    MODE_BEAT  = 1'b0,
    MODE_FRAME = 1'b1
  } mode_e;

  function automatic int unsigned prod_w(int unsigned dw);
    return 2 * dw;
  endfunction

  function automatic int unsigned sum_w(int unsigned dw, int unsigned nch);
    return prod_w(dw) + $clog2(nch);
  endfunction

  function automatic int unsigned tree_levels(int unsigned nch);
    return $clog2(nch);
  endfunction

endpackage

// File: rtl/dot_pipe_reg.sv
// Enable-gated delay line: data field plus valid bit; only the valid bits are reset.
module dot_pipe_reg #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             src_valid,
  input  logic [Width-1:0] src_data,
  output logic             dst_valid,
  output logic [Width-1:0] dst_data
);

  logic [Depth-1:0] valid_q;
  logic [Width-1:0] data_q [Depth];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (en) begin
      valid_q[0] <= src_valid;
      for (int i = 1; i < Depth; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      data_q[0] <= src_data;
      for (int i = 1; i < Depth; i++) data_q[i] <= data_q[i-1];
    end
  end

  assign dst_valid = valid_q[Depth-1];
  assign dst_data  = data_q[Depth-1];

endmodule

// File: rtl/dot_accum_engine.sv
// Pipelined NUM_CH-lane unsigned dot product with per-beat or saturating frame-accumulate output.
module dot_accum_engine
  import dot_accum_pkg::*;
#(
  parameter int unsigned DATAWIDTH  = 8,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned MUL_STAGES = 2,
  parameter int unsigned ADD_STAGES = 1,
  parameter int unsigned ACC_W      = 2 * DATAWIDTH + $clog2(NUM_CH) + 4,
  parameter int          INSTANCE_ID = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_valid,
  output logic                        i_ready,
  input  logic                        i_mode,
  input  logic                        i_last,
  input  logic [NUM_CH*DATAWIDTH-1:0] A,
  input  logic [NUM_CH*DATAWIDTH-1:0] B,
  output logic                        o_valid,
  input  logic                        o_ready,
  output logic [ACC_W-1:0]            o_data,
  output logic                        o_ovf
);

  localparam int unsigned ProdW  = prod_w(DATAWIDTH);
  localparam int unsigned SumW   = sum_w(DATAWIDTH, NUM_CH);
  localparam int unsigned Levels = tree_levels(NUM_CH);
  localparam int unsigned MulW   = NUM_CH * ProdW + 2;
  localparam int unsigned AddW   = SumW + 2;

  // The instance tag is only a label for retiming scripts; it must be non-negative.
  if (NUM_CH < 2 || MUL_STAGES < 1 || ADD_STAGES < 1 || ACC_W < SumW || INSTANCE_ID < 0)
  begin : g_param_check
    $error("dot_accum_engine: illegal parameter set");
  end

  logic en;
  assign en      = !(o_valid && !o_ready);
  assign i_ready = en;

  logic [NUM_CH*ProdW-1:0] prod;
  always_comb begin
    prod = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      prod[k*ProdW +: ProdW] = ProdW'(A[k*DATAWIDTH +: DATAWIDTH]) *
                               ProdW'(B[k*DATAWIDTH +: DATAWIDTH]);
    end
  end

  logic            mul_valid;
  logic [MulW-1:0] mul_data;

  dot_pipe_reg #(.Width(MulW), .Depth(MUL_STAGES)) u_mul_pipe (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .src_valid(i_valid),
    .src_data ({i_mode, i_last, prod}),
    .dst_valid(mul_valid),
    .dst_data (mul_data)
  );

  // Pairwise tree; an odd leftover node is forwarded unchanged to the next level.
  logic [SumW-1:0] node [Levels+1][NUM_CH];
  logic [SumW-1:0] tree_sum;
  always_comb begin
    int cnt;
    node = '{default: '0};
    for (int k = 0; k < NUM_CH; k++) node[0][k] = SumW'(mul_data[k*ProdW +: ProdW]);
    cnt = NUM_CH;
    for (int l = 0; l < Levels; l++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (2 * i + 1 < cnt) node[l+1][i] = node[l][2*i] + node[l][2*i+1];
        else if (2 * i + 1 == cnt) node[l+1][i] = node[l][2*i];
      end
      cnt = (cnt + 1) / 2;
    end
    tree_sum = node[Levels][0];
  end

  logic            add_valid;
  logic [AddW-1:0] add_data;

  dot_pipe_reg #(.Width(AddW), .Depth(ADD_STAGES)) u_add_pipe (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .src_valid(mul_valid),
    .src_data ({mul_data[MulW-1 -: 2], tree_sum}),
    .dst_valid(add_valid),
    .dst_data (add_data)
  );

  mode_e           beat_mode;
  logic            beat_last;
  logic [SumW-1:0] beat_sum;
  assign beat_mode = mode_e'(add_data[SumW+1]);
  assign beat_last = add_data[SumW];
  assign beat_sum  = add_data[SumW-1:0];

  logic [ACC_W-1:0] acc_q, acc_d, data_q, data_d, sat_val;
  logic             ovf_acc_q, ovf_acc_d, valid_q, valid_d, ovf_q, ovf_d;
  logic [ACC_W:0]   acc_sum;
  logic             sat_ovf;

  // acc never exceeds 2^ACC_W-1, so one carry bit is enough to detect overflow.
  assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(beat_sum);
  assign sat_ovf = acc_sum[ACC_W];
  assign sat_val = sat_ovf ? '1 : acc_sum[ACC_W-1:0];

  always_comb begin
    acc_d     = acc_q;
    ovf_acc_d = ovf_acc_q;
    valid_d   = valid_q;
    data_d    = data_q;
    ovf_d     = ovf_q;
    if (en) begin
      valid_d = 1'b0;
      if (add_valid) begin
        if (beat_mode == MODE_BEAT) begin
          valid_d   = 1'b1;
          data_d    = ACC_W'(beat_sum);
          ovf_d     = 1'b0;
          acc_d     = '0;
          ovf_acc_d = 1'b0;
        end else if (!beat_last) begin
          acc_d     = sat_val;
          ovf_acc_d = ovf_acc_q | sat_ovf;
        end else begin
          valid_d   = 1'b1;
          data_d    = sat_val;
          ovf_d     = ovf_acc_q | sat_ovf;
          acc_d     = '0;
          ovf_acc_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q     <= '0;
      ovf_acc_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      ovf_acc_q <= ovf_acc_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_ovf   = ovf_q;

endmodule

// File: doc/dot_accum_engine.md
Name: dot_accum_engine

Overview:
Parametrised successor to the fixed four-input square-and-sum datapath. Computes a NUM_CH-lane unsigned dot product A·B per beat through a pipelined multiply stage and a pipelined adder tree. Adds a frame-accumulate mode with saturation and an overflow flag, plus ready/valid backpressure. Sits between the feature front-end and the result FIFO in the retiming test designs.

Parameters:
DATAWIDTH, 8, width of each unsigned lane operand.
NUM_CH, 4, number of lanes; any value >= 2, need not be a power of two.
MUL_STAGES, 2, register stages in the multiply section (>= 1).
ADD_STAGES, 1, register stages in the adder-tree section (>= 1).
ACC_W, 2*DATAWIDTH+$clog2(NUM_CH)+4, accumulator and output width; must be >= SUM_W.
INSTANCE_ID, 0, instance tag passed through for retiming scripts; no functional effect.

Ports:
clk  input  1  clock; all state on rising edge.
rst  input  1  asynchronous, active-low reset (asserts immediately when low, releases synchronously to clk).
i_valid  input  1  input beat valid.
i_ready  output  1  block can accept a beat this cycle.
i_mode  input  1  0 = per-beat output; 1 = accumulate over frame. Sampled with the beat.
i_last  input  1  last beat of a frame; meaningful only when i_mode=1.
A  input  NUM_CH*DATAWIDTH  lane k operand at bits [k*DATAWIDTH +: DATAWIDTH].
B  input  NUM_CH*DATAWIDTH  second operand; same packing as A.
o_valid  output  1  result valid.
o_ready  input  1  downstream accepts the result.
o_data  output  ACC_W  result, zero-extended or saturated.
o_ovf  output  1  result was saturated; qualified by o_valid.

Behaviour:
- Widths: PROD_W = 2*DATAWIDTH. SUM_W = PROD_W + $clog2(NUM_CH). All arithmetic is unsigned with no truncation before the accumulator.
- Handshake:
  - Input beat accepted when i_valid && i_ready.
  - Output transfer occurs when o_valid && o_ready.
  - Global stall: every pipeline register, including valid bits, holds when o_valid && !o_ready.
  - i_ready = !(o_valid && !o_ready), so it is combinational from o_ready.
  - o_data, o_ovf and o_valid are stable while stalled.
- Pipeline:
  - Lane products registered through MUL_STAGES.
  - Balanced binary tree of sums registered through ADD_STAGES. Odd tree nodes pass through, delayed to match.
  - One accumulator/output register stage.
  - Latency L = MUL_STAGES + ADD_STAGES + 1 cycles from acceptance to o_valid, absent stalls.
  - Throughput is one beat per cycle.
  - mode and last bits travel with the beat's valid.
- Accumulator at the output stage:
  - Per-beat mode (mode=0): o_data = zero-extended tree sum. o_ovf = 0. acc cleared to 0. o_valid asserted.
  - mode=1 with !last: acc <= sat(acc + sum). Sticky ovf_acc |= overflow. No output.
  - mode=1 with last: o_data = sat(acc + sum). o_ovf = ovf_acc | overflow. o_valid asserted. acc and ovf_acc cleared.
  - sat(x): if x > 2^ACC_W-1, result is 2^ACC_W-1 and overflow = 1. Once saturated, acc stays at max for the rest of the frame.
- Mode switch mid-frame: a mode=0 beat arriving while acc is nonzero discards the partial frame. It outputs only its own sum, and both acc and ovf_acc are cleared.
- o_valid drops the cycle after a transfer unless a new result lands. Bubbles produce no output.
- Reset (rst low, any time including mid-frame or mid-stall):
  - All valid bits = 0, acc = 0, ovf_acc = 0.
  - o_valid = 0, o_data = 0, o_ovf = 0.
  - i_ready = 1.
  - Data pipeline registers need not be reset.
- Inputs when i_valid=0 are don't-care. X on A/B must not propagate to o_valid.

Decomposition:
- Package dot_accum_pkg:
  - Width functions prod_w(DATAWIDTH) and sum_w(DATAWIDTH, NUM_CH).
  - Tree depth function tree_levels(NUM_CH).
  - Typedef mode_e {MODE_BEAT=0, MODE_FRAME=1}.
- One sub-module, dot_pipe_reg: enable-gated delay line for a parametrised-width data field plus its valid, with reset on the valid bit only.
  - Used for the MUL stages, the ADD stages and the sideband (mode/last) alignment.
  - The adder tree is generated inline.

Test Plan:
- Defaults, mode=0, A=B=all 0xFF, o_ready=1 → o_data = 4*65025 = 260100, o_ovf=0, o_valid exactly 4 cycles after acceptance.
- Per-lane check, mode=0, A={1,2,3,4}, B={5,6,7,8} → o_data = 70. Back-to-back beats produce one result per cycle, in order.
- Frame, mode=1, 3 beats of A={1,2,3,4}, B={5,6,7,8} with last on beat 3 → a single o_valid with o_data = 210. Nothing is output for beats 1-2.
- Saturation, DATAWIDTH=4, ACC_W=14, mode=1, 19 beats of A=B=all 15 (900 each) → o_data = 16383, o_ovf=1. The next frame of 1 beat with last → o_data = 900, o_ovf=0.
- Backpressure, stream of 10 mode=0 beats with o_ready toggling 1,0,0,1,… → i_ready mirrors the stall. No result is lost or duplicated, and outputs stay stable while o_ready=0.
- Reset mid-frame after 2 accumulated beats, then a frame of 1 beat (A={1,1,1,1}, B={1,1,1,1}, last) → o_data = 4. Reset outputs all read 0.
